// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module : vga_timing_gen_if
// Scan coordinates, sync/blank and colour between raster timing and DAC side.
// Rev    : 1.0  initial release
// ============================================================================
interface vga_timing_gen_if;
    logic signed [10:0] pixelX;
    logic signed [10:0] pixelY;
    logic               startOfFrame;
    logic               hSyncN;
    logic               vSyncN;
    logic               blankN;
    logic        [7:0]  RGBout;
    logic        [7:0]  RGBin;

    modport master (
        output pixelX, pixelY, startOfFrame, hSyncN, vSyncN, blankN, RGBout,
        input  RGBin
    );

    modport slave (
        input  pixelX, pixelY, startOfFrame, hSyncN, vSyncN, blankN, RGBout,
        output RGBin
    );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module : vga_timing_gen
// VGA raster counters, pipelined sync/blank and registered colour output.
// Rev    : 1.0  initial release
// ============================================================================
module vga_timing_gen #(
    parameter int CLK_DIV  = 2,
    parameter int PIPE_DLY = 1,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  wire logic        clk,
    input  wire logic        resetN,
    vga_timing_gen_if.master vga
);
    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [2:0]  DIV_LAST = 3'(CLK_DIV - 1);
    localparam logic [10:0] H_LAST   = 11'(HT - 1);
    localparam logic [10:0] V_LAST   = 11'(VT - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEG   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [2:0]        div_cnt;
    logic              pix_en;
    logic [10:0]       h_cnt;
    logic [10:0]       v_cnt;
    logic              h_end;
    logic              v_end;
    logic              hs0;
    logic              vs0;
    logic              bl0;
    logic              bl_tap;
    logic [PIPE_DLY:0] hs_q;
    logic [PIPE_DLY:0] vs_q;
    logic [PIPE_DLY:0] bl_q;
    logic              sof_q;
    logic [7:0]        rgb_q;

    assign pix_en = (div_cnt == DIV_LAST);
    assign h_end  = (h_cnt == H_LAST);
    assign v_end  = (v_cnt == V_LAST);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            div_cnt <= '0;
        end else if (pix_en) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_end) begin
                h_cnt <= '0;
                v_cnt <= v_end ? 11'd0 : v_cnt + 11'd1;
            end else begin
                h_cnt <= h_cnt + 11'd1;
            end
        end
    end

    // Only the wrap fires the pulse, so the frame start right after reset is silent.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sof_q <= 1'b0;
        end else begin
            sof_q <= pix_en && h_end && v_end;
        end
    end

    assign hs0 = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
    assign vs0 = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
    assign bl0 = (h_cnt < H_ACT) && (v_cnt < V_ACT);

    // Index i of each delay vector holds the stage-(i+1) value.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hs_q <= '1;
            vs_q <= '1;
            bl_q <= '0;
        end else begin
            hs_q[0] <= hs0;
            vs_q[0] <= vs0;
            bl_q[0] <= bl0;
            for (int i = 1; i <= PIPE_DLY; i++) begin
                hs_q[i] <= hs_q[i-1];
                vs_q[i] <= vs_q[i-1];
                bl_q[i] <= bl_q[i-1];
            end
        end
    end

    generate
        if (PIPE_DLY == 0) begin : g_tap_raw
            assign bl_tap = bl0;
        end else begin : g_tap_reg
            assign bl_tap = bl_q[PIPE_DLY-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= bl_tap ? vga.RGBin : 8'h00;
        end
    end

    assign vga.pixelX       = $signed(h_cnt);
    assign vga.pixelY       = $signed(v_cnt);
    assign vga.startOfFrame = sof_q;
    assign vga.hSyncN       = hs_q[PIPE_DLY];
    assign vga.vSyncN       = vs_q[PIPE_DLY];
    assign vga.blankN       = bl_q[PIPE_DLY];
    assign vga.RGBout       = rgb_q;
endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module : tb_vga_timing_gen
// Four generator configurations checked every clk against a raster model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_vga_timing_gen;
    localparam int NCFG = 4;
    localparam int CD_T [NCFG] = '{1, 2, 1, 4};
    localparam int PD_T [NCFG] = '{1, 1, 3, 0};
    localparam int HA_T [NCFG] = '{640, 16, 16, 16};
    localparam int HF_T [NCFG] = '{16, 2, 2, 3};
    localparam int HS_T [NCFG] = '{96, 4, 3, 2};
    localparam int HB_T [NCFG] = '{48, 3, 4, 1};
    localparam int VA_T [NCFG] = '{480, 8, 6, 5};
    localparam int VF_T [NCFG] = '{10, 1, 2, 1};
    localparam int VS_T [NCFG] = '{2, 2, 1, 2};
    localparam int VB_T [NCFG] = '{33, 2, 2, 1};
    // 0: random colour, 1: constant 8'hAC, 2: colour = pixelX low byte PIPE_DLY clk late
    localparam int MODE_T [NCFG] = '{1, 0, 2, 0};

    logic clk = 1'b0;
    logic resetN = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    task automatic chk(input int cfg, input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL cfg%0d %s t=%0t actual=%0d expected=%0d", cfg, nm, $time, act, exp);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int CD   = CD_T[g];
        localparam int PD   = PD_T[g];
        localparam int HA   = HA_T[g];
        localparam int HF   = HF_T[g];
        localparam int HS   = HS_T[g];
        localparam int VA   = VA_T[g];
        localparam int VF   = VF_T[g];
        localparam int VS   = VS_T[g];
        localparam int HT   = HA + HF + HS + HB_T[g];
        localparam int VT   = VA + VF + VS + VB_T[g];
        localparam int MODE = MODE_T[g];

        vga_timing_gen_if vif ();

        vga_timing_gen #(
            .CLK_DIV (CD),     .PIPE_DLY(PD),
            .H_ACTIVE(HA),     .H_FP(HF), .H_SYNC(HS), .H_BP(HB_T[g]),
            .V_ACTIVE(VA),     .V_FP(VF), .V_SYNC(VS), .V_BP(VB_T[g])
        ) dut (
            .clk   (clk),
            .resetN(resetN),
            .vga   (vif)
        );

        logic [7:0] hist [64];
        int   n           = 0;
        int   t           = 0;
        int   hs_low_len  = -1;
        int   cur_low     = 0;
        int   bl_high_len = -1;
        int   cur_high    = 0;
        int   line_per    = -1;
        int   last_fall   = -1;
        int   sof_per     = -1;
        int   last_sof    = -1;
        int   first_one   = -1;
        logic prev_hs     = 1'b1;

        // m = clk edges since reset release; pixel index advances once per CD edges
        function automatic int hpos(input int m);
            return (m / CD) % HT;
        endfunction

        function automatic int vpos(input int m);
            return ((m / CD) / HT) % VT;
        endfunction

        // {hsync_n, vsync_n, blank_n} decoded from the raster position at m
        function automatic logic [2:0] raw(input int m);
            int h;
            int v;
            if (m < 0) return 3'b110;
            h = hpos(m);
            v = vpos(m);
            return {!(h >= HA + HF && h < HA + HF + HS),
                    !(v >= VA + VF && v < VA + VF + VS),
                    (h < HA) && (v < VA)};
        endfunction

        initial begin
            logic [2:0] s_out;
            int         exp_rgb;
            int         p;
            vif.RGBin = 8'h00;
            forever begin
                @(posedge clk);
                t++;
                if (resetN) n++;
                else        n = 0;
                #1;
                s_out   = raw(n - PD - 1);
                exp_rgb = (n >= 1 && s_out[0]) ? int'(hist[(n - 1) % 64]) : 0;
                p       = n / CD;
                chk(g, "pixelX", int'(vif.pixelX), hpos(n));
                chk(g, "pixelY", int'(vif.pixelY), vpos(n));
                chk(g, "hSyncN", int'(vif.hSyncN), int'(s_out[2]));
                chk(g, "vSyncN", int'(vif.vSyncN), int'(s_out[1]));
                chk(g, "blankN", int'(vif.blankN), int'(s_out[0]));
                chk(g, "RGBout", int'(vif.RGBout), exp_rgb);
                chk(g, "startOfFrame", int'(vif.startOfFrame),
                    int'((n % CD == 0) && p > 0 && (p % (HT * VT) == 0)));

                if (!resetN) begin
                    cur_low   = 0;
                    cur_high  = 0;
                    last_fall = -1;
                    last_sof  = -1;
                    prev_hs   = 1'b1;
                end else begin
                    if (!vif.hSyncN) cur_low++;
                    else if (cur_low > 0) begin hs_low_len = cur_low; cur_low = 0; end
                    if (vif.blankN) cur_high++;
                    else if (cur_high > 0) begin bl_high_len = cur_high; cur_high = 0; end
                    if (prev_hs && !vif.hSyncN) begin
                        if (last_fall >= 0) line_per = t - last_fall;
                        last_fall = t;
                    end
                    prev_hs = vif.hSyncN;
                    if (vif.startOfFrame) begin
                        if (last_sof >= 0) sof_per = t - last_sof;
                        last_sof = t;
                    end
                    if (first_one < 0 && vif.pixelX == 11'sd1) first_one = n;
                end

                if (MODE == 1)                 vif.RGBin = 8'hAC;
                else if (MODE == 2 && n >= PD) vif.RGBin = 8'(hpos(n - PD));
                else                           vif.RGBin = 8'($urandom_range(0, 255));
                hist[n % 64] = vif.RGBin;
            end
        end

        // Reset must act without waiting for a clock edge
        always @(negedge resetN) begin
            #1;
            chk(g, "rst_pixelX", int'(vif.pixelX), 0);
            chk(g, "rst_pixelY", int'(vif.pixelY), 0);
            chk(g, "rst_hSyncN", int'(vif.hSyncN), 1);
            chk(g, "rst_vSyncN", int'(vif.vSyncN), 1);
            chk(g, "rst_blankN", int'(vif.blankN), 0);
            chk(g, "rst_RGBout", int'(vif.RGBout), 0);
            chk(g, "rst_sof", int'(vif.startOfFrame), 0);
        end
    end

    initial begin
        #2 resetN = 1'b0;
        repeat (3) @(negedge clk);
        resetN = 1'b1;
        repeat (2600) @(posedge clk);

        chk(0, "hsync_low_clk", g_cfg[0].hs_low_len, 96);
        chk(0, "blank_high_clk", g_cfg[0].bl_high_len, 640);
        chk(0, "line_period_clk", g_cfg[0].line_per, 800);
        chk(1, "first_pixelX_inc_clk", g_cfg[1].first_one, 2);

        @(posedge clk);
        #3 resetN = 1'b0;
        repeat (3) @(negedge clk);
        resetN = 1'b1;
        repeat (3000) @(posedge clk);

        chk(0, "hsync_low_clk_after_rst", g_cfg[0].hs_low_len, 96);
        chk(0, "line_period_clk_after_rst", g_cfg[0].line_per, 800);
        chk(1, "frame_period_clk", g_cfg[1].sof_per, 650);
        chk(2, "frame_period_clk", g_cfg[2].sof_per, 275);
        chk(3, "frame_period_clk", g_cfg[3].sof_per, 792);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
